// File: rtl/dmem_pkg.sv
// Shared funct3 codes, FSM encoding and byte-enable helper for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Undefined funct3 codes fall through to full-word access.
  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: byte_en = 4'b0001 << off;
      F3_H, F3_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load-lane extraction: picks byte/half/word from the addressed word and sign/zero-extends it.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'h0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'h0, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressable data memory with fixed wait states and a combinational Stall to the core.
// Optional DMEM_MISALIGN_EN adds the Misaligned output and suppresses misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int    DEPTH       = 1024,
  parameter int    WAIT_STATES = 2,
  parameter string MEM_INIT    = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        Stall
`ifdef DMEM_MISALIGN_EN
  ,
  output logic        Misaligned
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [3:0][7:0] mem [DEPTH];

  state_e        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          req, done, mis;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [3:0]    be;
  logic [31:0]   wdata, ext;
  logic          unused_addr;

  assign req         = MemRead | MemWrite;
  assign idx         = Mem_WrAddr[AW+1:2];
  assign off         = Mem_WrAddr[1:0];
  assign unused_addr = ^Mem_WrAddr[31:AW+2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    Stall     = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        if (WAIT_STATES == 0) done = 1'b1;
        else begin
          Stall     = 1'b1;
          state_nxt = ST_BUSY;
          cnt_nxt   = 4'(WAIT_STATES - 1);
        end
      end
      ST_BUSY: if (cnt != 4'd0) begin
        Stall   = 1'b1;
        cnt_nxt = cnt - 4'd1;
      end else begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Reset is asynchronous, so it must also mask the combinational outputs.
    if (reset) begin
      Stall = 1'b0;
      done  = 1'b0;
    end
  end

`ifdef DMEM_MISALIGN_EN
  always_comb begin
    mis = 1'b0;
    if (done) begin
      case (Funct3)
        F3_B, F3_BU: mis = 1'b0;
        F3_H, F3_HU: mis = off[0];
        default:     mis = |off;
      endcase
    end
  end
  assign Misaligned = mis;
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    be = byte_en(Funct3, off);
    case (Funct3)
      F3_B, F3_BU: wdata = {4{Mem_WrData[7:0]}};
      F3_H, F3_HU: wdata = {2{Mem_WrData[15:0]}};
      default:     wdata = Mem_WrData;
    endcase
  end

  always_ff @(posedge clk) begin
    if (done && MemWrite && !mis) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][i] <= wdata[8*i +: 8];
    end
  end

  // Combinational read sees the array before any write at the closing edge.
  dmem_load_ext u_load_ext (
    .word   (mem[idx]),
    .off    (off),
    .funct3 (Funct3),
    .data   (ext)
  );

  assign ReadData = (done && MemRead && !mis) ? ext : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: instance 0 has two wait states, instance 1 is zero-wait.
module tb_dmem_responder;
  import dmem_pkg::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  logic        clk = 1'b0;
  logic        reset;
  req_t        rq [2];
  logic [31:0] rdata [2];
  logic        stall [2];
`ifdef DMEM_MISALIGN_EN
  logic        mis [2];
`endif

  logic [31:0] sb [$];
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .MemRead(rq[0].rd), .MemWrite(rq[0].wr), .Funct3(rq[0].f3),
    .Mem_WrAddr(rq[0].a), .Mem_WrData(rq[0].d),
    .ReadData(rdata[0]), .Stall(stall[0])
`ifdef DMEM_MISALIGN_EN
    , .Misaligned(mis[0])
`endif
  );

  dmem_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .MemRead(rq[1].rd), .MemWrite(rq[1].wr), .Funct3(rq[1].f3),
    .Mem_WrAddr(rq[1].a), .Mem_WrData(rq[1].d),
    .ReadData(rdata[1]), .Stall(stall[1])
`ifdef DMEM_MISALIGN_EN
    , .Misaligned(mis[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one access, count stall cycles, then compare the completion cycle.
  task automatic access(input int w, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input int ws, input logic exp_mis, input string tag);
    int st;
    logic [31:0] e;
    rq[w] = '{rd, wr, f3, a, d};
    sb.push_back(rd ? exp : 32'h0);
    st = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!stall[w]) break;
      st++;
      chk({tag, "_stall_rdata"}, rdata[w], 32'h0);
    end
    chk({tag, "_stalls"}, st, ws);
    e = (sb.size() != 0) ? sb.pop_front() : 32'hxxxxxxxx;
    chk({tag, "_rdata"}, rdata[w], e);
`ifdef DMEM_MISALIGN_EN
    chk({tag, "_mis"}, mis[w], exp_mis);
`else
    if (exp_mis) chk({tag, "_mis_unexpected"}, 32'h0, 32'h1);
`endif
    @(posedge clk); #1;
  endtask

  task automatic idle(input int w, input int n);
    rq[w] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0};
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) rq[i] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0};
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_stall_a", stall[0], 1'b0);
    chk("rst_rdata_a", rdata[0], 32'h0);
    rq[0] = '{1'b1, 1'b0, F3_W, 32'h10, 32'h0};
    #1;
    chk("rst_req_stall_a", stall[0], 1'b0);
    rq[0] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0};
    reset = 1'b0;
    @(posedge clk); #1;

    // Word round trip, two wait states each.
    access(0, 0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        2, 0, "sw10");
    access(0, 1, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 2, 0, "lw10");
    // Byte store and sign/zero extension.
    access(0, 0, 1, F3_B,  32'h11, 32'hFFFFFF80, 32'h0,        2, 0, "sb11");
    access(0, 1, 0, F3_B,  32'h11, 32'h0,        32'hFFFFFF80, 2, 0, "lb11");
    access(0, 1, 0, F3_BU, 32'h11, 32'h0,        32'h00000080, 2, 0, "lbu11");
    access(0, 1, 0, F3_W,  32'h10, 32'h0,        32'hDEAD80EF, 2, 0, "lw10b");
    // Halfword store, back-to-back accesses.
    access(0, 0, 1, F3_H,  32'h12, 32'h12348001, 32'h0,        2, 0, "sh12");
    access(0, 1, 0, F3_H,  32'h12, 32'h0,        32'hFFFF8001, 2, 0, "lh12");
    access(0, 1, 0, F3_HU, 32'h12, 32'h0,        32'h00008001, 2, 0, "lhu12");
    access(0, 1, 0, F3_W,  32'h10, 32'h0,        32'h800180EF, 2, 0, "lw10c");
    access(0, 1, 0, 3'b011, 32'h10, 32'h0,       32'h800180EF, 2, 0, "lundef");
    idle(0, 2);
    chk("idle_rdata", rdata[0], 32'h0);
    chk("idle_stall", stall[0], 1'b0);

    // Store interrupted by reset must not commit.
    access(0, 0, 1, F3_W, 32'h20, 32'hCAFEF00D, 32'h0, 2, 0, "sw20");
    rq[0] = '{1'b0, 1'b1, F3_W, 32'h20, 32'h12345678};
    @(negedge clk);
    chk("rstmid_pre_stall", stall[0], 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rstmid_stall", stall[0], 1'b0);
    chk("rstmid_rdata", rdata[0], 32'h0);
`ifdef DMEM_MISALIGN_EN
    chk("rstmid_mis", mis[0], 1'b0);
`endif
    @(posedge clk); #1;
    rq[0] = '{1'b0, 1'b0, 3'b000, 32'h0, 32'h0};
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    access(0, 1, 0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 2, 0, "lw20");

`ifdef DMEM_MISALIGN_EN
    access(0, 0, 1, F3_W, 32'h22, 32'h00000055, 32'h0, 2, 1, "sw22mis");
    access(0, 1, 0, F3_W, 32'h20, 32'h0, 32'hCAFEF00D, 2, 0, "lw20b");
    access(0, 1, 0, F3_H, 32'h21, 32'h0, 32'h0,        2, 1, "lh21mis");
`else
    // Halfword ignores addr[0]; word ignores addr[1:0].
    access(0, 1, 0, F3_H, 32'h13, 32'h0, 32'hFFFF8001, 2, 0, "lh13");
    access(0, 1, 0, F3_W, 32'h12, 32'h0, 32'h800180EF, 2, 0, "lw12");
`endif
    idle(0, 1);

    // Zero-wait instance: never stalls, upper address bits wrap.
    access(1, 0, 1, F3_W, 32'h3FFC, 32'hA5A51234, 32'h0,        0, 0, "z_sw3ffc");
    access(1, 1, 0, F3_W, 32'h3FFC, 32'h0,        32'hA5A51234, 0, 0, "z_lw3ffc");
    access(1, 0, 1, F3_W, 32'h0,    32'h11223344, 32'h0,        0, 0, "z_sw0");
    access(1, 1, 0, F3_W, 32'h1000, 32'h0,        32'h11223344, 0, 0, "z_lw1000");
    access(1, 0, 1, F3_B, 32'h1001, 32'h00000055, 32'h0,        0, 0, "z_sb1001");
    access(1, 1, 0, F3_W, 32'h0,    32'h0,        32'h11225544, 0, 0, "z_lw0");
    idle(1, 1);
    chk("z_idle_rdata", rdata[1], 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
